// File: rtl/klein_key_sched.sv
// KLEIN-80 decryption key scheduler: expands a master key into NR+1
// round keys, then streams them last-first over a valid/ready handshake.
module klein_key_sched #(
    parameter int NR = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [79:0] key_in,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic        flush,
    output logic [63:0] rk_out,
    output logic [4:0]  rk_index,
    output logic        rk_valid,
    input  logic        rk_ready,
    output logic        rk_last,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        SERVE
    } state_t;

    state_t      state_q, state_d;
    logic [79:0] k_q, k_d;
    logic [7:0]  r_q, r_d;
    logic [4:0]  idx_q, idx_d;
    logic [63:0] slot_q [NR+1];

    logic        slot_we;
    logic [4:0]  slot_wa;
    logic [63:0] slot_wd;
    logic [79:0] k_step;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h7;
            4'h1: y = 4'h4;
            4'h2: y = 4'hA;
            4'h3: y = 4'h9;
            4'h4: y = 4'h1;
            4'h5: y = 4'hF;
            4'h6: y = 4'hB;
            4'h7: y = 4'h0;
            4'h8: y = 4'hC;
            4'h9: y = 4'h3;
            4'hA: y = 4'h2;
            4'hB: y = 4'h6;
            4'hC: y = 4'h8;
            4'hD: y = 4'hE;
            4'hE: y = 4'hD;
            default: y = 4'h5;
        endcase
        return y;
    endfunction

    function automatic logic [79:0] step(input logic [79:0] k,
                                         input logic [7:0]  r);
        logic [39:0] a, b, up, dn;
        a  = {k[71:40], k[79:72]};
        b  = {k[31:0], k[39:32]};
        // round counter lands in result bits [63:56]
        up = b ^ {16'd0, r, 16'd0};
        dn = a ^ b;
        for (int i = 4; i < 8; i++) begin
            dn[4*i +: 4] = sbox(dn[4*i +: 4]);
        end
        return {up, dn};
    endfunction

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        r_d     = r_q;
        idx_d   = idx_q;
        slot_we = 1'b0;
        slot_wa = 5'd0;
        slot_wd = 64'd0;
        k_step  = step(k_q, r_q);
        if (flush) begin
            state_d = IDLE;
            r_d     = 8'd0;
            idx_d   = 5'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (key_valid) begin
                        k_d     = key_in;
                        r_d     = 8'd1;
                        state_d = EXPAND;
                        slot_we = 1'b1;
                        slot_wd = key_in[79:16];
                    end
                end
                EXPAND: begin
                    k_d     = k_step;
                    slot_we = 1'b1;
                    slot_wa = r_q[4:0];
                    slot_wd = k_step[79:16];
                    if (r_q == 8'(NR)) begin
                        state_d = SERVE;
                        idx_d   = 5'(NR);
                        r_d     = 8'd0;
                    end else begin
                        r_d = r_q + 8'd1;
                    end
                end
                SERVE: begin
                    if (rk_ready) begin
                        if (idx_q == 5'd0) begin
                            state_d = IDLE;
                        end else begin
                            idx_d = idx_q - 5'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= 80'd0;
            r_q     <= 8'd0;
            idx_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            r_q     <= r_d;
            idx_q   <= idx_d;
        end
    end

    // key storage is never reset; contents are only read in SERVE
    always_ff @(posedge clk) begin
        if (slot_we) begin
            slot_q[slot_wa] <= slot_wd;
        end
    end

    assign key_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rk_valid  = (state_q == SERVE);
    assign rk_out    = rk_valid ? slot_q[idx_q] : 64'd0;
    assign rk_index  = rk_valid ? idx_q : 5'd0;
    assign rk_last   = rk_valid && (idx_q == 5'd0);

endmodule

// File: tb/tb_klein_key_sched.sv
// Self-checking bench for klein_key_sched: directed scenarios plus a
// scoreboard that checks every presented round key against a model.
module tb_klein_key_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [79:0] key_in = 80'd0;
    logic        key_valid = 1'b0;
    logic        key_ready;
    logic        flush = 1'b0;
    logic [63:0] rk_out;
    logic [4:0]  rk_index;
    logic        rk_valid;
    logic        rk_ready = 1'b1;
    logic        rk_last;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_hs = 0;

    bit          model_active = 1'b0;
    int          exp_next = 0;
    logic [63:0] exp_keys [17];
    logic [3:0]  sb [16] = '{4'h7, 4'h4, 4'hA, 4'h9, 4'h1, 4'hF, 4'hB, 4'h0,
                             4'hC, 4'h3, 4'h2, 4'h6, 4'h8, 4'hE, 4'hD, 4'h5};

    klein_key_sched #(.NR(16)) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
        .key_ready(key_ready), .flush(flush), .rk_out(rk_out),
        .rk_index(rk_index), .rk_valid(rk_valid), .rk_ready(rk_ready),
        .rk_last(rk_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [79:0] act,
                       input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [79:0] model_step(input logic [79:0] k,
                                               input int r);
        logic [39:0] hi, lo, a, b, up, dn;
        hi = k[79:40];
        lo = k[39:0];
        for (int i = 0; i < 40; i++) begin
            a[(i + 8) % 40] = hi[i];
            b[(i + 8) % 40] = lo[i];
        end
        up = b;
        for (int i = 0; i < 8; i++) up[16 + i] = b[16 + i] ^ r[i];
        dn = a ^ b;
        for (int n = 4; n < 8; n++) dn[n*4 +: 4] = sb[int'(dn[n*4 +: 4])];
        return {up, dn};
    endfunction

    task automatic model_load(input logic [79:0] k);
        logic [79:0] s;
        s = k;
        exp_keys[0] = k[79:16];
        for (int r = 1; r <= 16; r++) begin
            s = model_step(s, r);
            exp_keys[r] = s[79:16];
        end
        exp_next = 16;
        model_active = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rk_valid) begin
                if (!model_active) begin
                    chk("unexpected_valid", {79'd0, rk_valid}, 80'd0);
                end else begin
                    chk("sb_index", {75'd0, rk_index}, 80'(exp_next));
                    chk("sb_key", {16'd0, rk_out}, {16'd0, exp_keys[exp_next]});
                    chk("sb_last", {79'd0, rk_last}, {79'd0, exp_next == 0});
                    if (rk_ready) begin
                        n_hs++;
                        if (exp_next == 0) model_active = 1'b0;
                        exp_next--;
                    end
                end
            end else begin
                chk("idle_outputs", {9'd0, rk_out, rk_index, rk_last}, 80'd0);
            end
            chk("ready_vs_busy", {79'd0, key_ready}, {79'd0, !busy});
        end
    end

    task automatic load_key(input logic [79:0] k);
        model_load(k);
        @(posedge clk); #1;
        key_in = k;
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!rk_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_index(input int target);
        int t = 0;
        while (!(rk_valid && int'(rk_index) == target) && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("wait_index_reached", {75'd0, rk_index}, 80'(target));
    endtask

    task automatic wait_done(input int h0);
        int t = 0;
        @(negedge clk);
        while (!(key_ready && !busy) && t < 80) begin
            @(negedge clk);
            t++;
        end
        chk("done_idle", {79'd0, key_ready}, 80'd1);
        chk("stream_count", 80'(n_hs - h0), 80'd17);
    endtask

    task automatic run_zero();
        int n;
        int h0 = n_hs;
        load_key(80'd0);
        wait_valid(n);
        chk("z_latency", 80'(n), 80'd17);
        for (int i = 0; i <= 16; i++) begin
            chk("z_index_seq", {75'd0, rk_index}, 80'(16 - i));
            if (i == 15) chk("z_idx1_lit", {16'd0, rk_out}, 80'h0000010000007777);
            if (i == 16) begin
                chk("z_idx0_zero", {16'd0, rk_out}, 80'd0);
                chk("z_idx0_last", {79'd0, rk_last}, 80'd1);
            end
            if (i < 16) @(negedge clk);
        end
        @(negedge clk);
        chk("z_ready_after", {79'd0, key_ready}, 80'd1);
        chk("z_valid_after", {79'd0, rk_valid}, 80'd0);
        chk("z_count", 80'(n_hs - h0), 80'd17);
    endtask

    initial begin
        int n, h0, cnt;
        logic [79:0] m;
        logic [63:0] held;

        m = model_step(80'd0, 1);
        chk("model_z1", {16'd0, m[79:16]}, 80'h0000010000007777);
        m = model_step(m, 2);
        chk("model_z2", {16'd0, m[79:16]}, 80'h7777020000770B77);
        m = model_step({80{1'b1}}, 1);
        chk("model_f1", {16'd0, m[79:16]}, 80'hFFFFFEFFFF007777);

        #3;
        chk("rst_key_ready", {79'd0, key_ready}, 80'd1);
        chk("rst_outs", {9'd0, rk_out, rk_index, rk_last}, 80'd0);
        chk("rst_valid_busy", {78'd0, rk_valid, busy}, 80'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_zero();

        h0 = n_hs;
        load_key({80{1'b1}});
        wait_valid(n);
        chk("f_latency", 80'(n), 80'd17);
        wait_done(h0);

        h0 = n_hs;
        load_key(80'h0123456789ABCDEF0123);
        wait_valid(n);
        wait_index(11);
        @(posedge clk); #1;
        rk_ready = 1'b0;
        @(negedge clk);
        held = rk_out;
        chk("bp_index", {75'd0, rk_index}, 80'd10);
        repeat (4) begin
            @(negedge clk);
            chk("bp_hold_idx", {75'd0, rk_index}, 80'd10);
            chk("bp_hold_key", {16'd0, rk_out}, {16'd0, held});
        end
        @(posedge clk); #1;
        rk_ready = 1'b1;
        @(negedge clk);
        chk("bp_still10", {75'd0, rk_index}, 80'd10);
        @(negedge clk);
        chk("bp_next9", {75'd0, rk_index}, 80'd9);
        wait_done(h0);

        h0 = n_hs;
        load_key(80'hA5A5_5A5A_0F0F_F0F0_1234);
        repeat (3) @(posedge clk);
        #1;
        chk("ign_key_ready", {79'd0, key_ready}, 80'd0);
        key_in = 80'hDEAD_BEEF_CAFE_F00D_9999;
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
        wait_done(h0);

        load_key(80'h1111_2222_3333_4444_5555);
        repeat (6) @(posedge clk);
        #1;
        chk("fl_busy_before", {79'd0, busy}, 80'd1);
        flush = 1'b1;
        model_active = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("fl_idle", {78'd0, key_ready, busy}, 80'd2);
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (rk_valid) cnt++;
        end
        chk("fl_no_valid", 80'(cnt), 80'd0);
        h0 = n_hs;
        load_key(80'h0F1E_2D3C_4B5A_6978_8796);
        wait_valid(n);
        chk("fl_new_latency", 80'(n), 80'd17);
        wait_done(h0);

        load_key(80'd0);
        wait_valid(n);
        wait_index(5);
        #2;
        model_active = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", {9'd0, rk_out, rk_index, rk_last}, 80'd0);
        chk("mid_rst_flags", {77'd0, rk_valid, busy, key_ready}, 80'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        run_zero();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
